async_fifo_drain: RTL and testbench

//  Read-side agent for the asynchronous FIFO. Runs on the consumer clock RCLK.

---
 rtl/async_fifo_drain.sv | 152 +++++++++++++++
 tb/tb_async_fifo_drain.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/async_fifo_drain.sv
// Read-side drain agent for the async FIFO: syncs EMPTY, pulses R_EN, queues words for a valid/ready sink.
// Optional DRAIN_STATS_EN adds saturating WORD_CNT / STALL_CNT outputs.
module async_fifo_drain #(
   parameter int unsigned P_DATA_WIDTH = 8,
   parameter int unsigned SYNC_STAGES  = 2,
   parameter int unsigned RD_PULSE_W   = 1
) (
   input  logic                    RCLK,
   input  logic                    RST_n,
   input  logic                    FIFO_EMPTY,
   input  logic [P_DATA_WIDTH-1:0] FIFO_DATA,
   output logic                    R_EN,
   output logic                    OUT_VALID,
   input  logic                    OUT_READY,
`ifdef DRAIN_STATS_EN
   output logic [31:0]             WORD_CNT,
   output logic [31:0]             STALL_CNT,
`endif
   output logic [P_DATA_WIDTH-1:0] OUT_DATA
);

   localparam int unsigned SETTLE_CYC = SYNC_STAGES + 1;
   localparam int unsigned TMR_MAX    = (RD_PULSE_W > SETTLE_CYC) ? RD_PULSE_W : SETTLE_CYC;
   localparam int unsigned TMR_W      = $clog2(TMR_MAX + 1);
   localparam int unsigned CNT_W      = 2;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_PULSE,
      ST_SETTLE
   } state_t;

   state_t                  state;
   logic [TMR_W-1:0]        tmr;
   logic [SYNC_STAGES-1:0]  sync_q;
   logic                    empty_s;
   logic [CNT_W-1:0]        cnt;
   logic [P_DATA_WIDTH-1:0] q1;
   logic                    push_c;
   logic                    pop_c;

   // EMPTY synchronizer; resets to "empty" so nothing is read until the flag is seen low
   always_ff @(posedge RCLK or negedge RST_n) begin
      if (!RST_n) begin
         sync_q <= '1;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], FIFO_EMPTY};
      end
   end

   assign empty_s = sync_q[SYNC_STAGES-1];

   // Read sequencer: PULSE holds R_EN, SETTLE waits for the new EMPTY value to cross
   always_ff @(posedge RCLK or negedge RST_n) begin
      if (!RST_n) begin
         state <= ST_IDLE;
         tmr   <= '0;
         R_EN  <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (!empty_s && (cnt < CNT_W'(2))) begin
                  state <= ST_PULSE;
                  tmr   <= TMR_W'(RD_PULSE_W - 1);
                  R_EN  <= 1'b1;
               end
            end
            ST_PULSE: begin
               if (tmr == '0) begin
                  state <= ST_SETTLE;
                  tmr   <= TMR_W'(SYNC_STAGES);
                  R_EN  <= 1'b0;
               end else begin
                  tmr <= tmr - TMR_W'(1);
               end
            end
            ST_SETTLE: begin
               if (tmr == '0) begin
                  state <= ST_IDLE;
               end else begin
                  tmr <= tmr - TMR_W'(1);
               end
            end
            default: begin
               state <= ST_IDLE;
               tmr   <= '0;
               R_EN  <= 1'b0;
            end
         endcase
      end
   end

   assign push_c = (state == ST_PULSE) && (tmr == '0);
   assign pop_c  = OUT_VALID && OUT_READY;

   // Two-entry output queue; OUT_DATA is the head register, q1 the tail
   always_ff @(posedge RCLK or negedge RST_n) begin
      if (!RST_n) begin
         cnt       <= '0;
         OUT_VALID <= 1'b0;
         OUT_DATA  <= '0;
         q1        <= '0;
      end else begin
         case ({push_c, pop_c})
            2'b10: begin
               if (cnt == '0) begin
                  OUT_DATA <= FIFO_DATA;
               end else begin
                  q1 <= FIFO_DATA;
               end
               if (cnt != CNT_W'(2)) begin
                  cnt <= cnt + CNT_W'(1);
               end
               OUT_VALID <= 1'b1;
            end
            2'b01: begin
               OUT_DATA  <= q1;
               cnt       <= cnt - CNT_W'(1);
               OUT_VALID <= (cnt != CNT_W'(1));
            end
            2'b11: begin
               if (cnt == CNT_W'(1)) begin
                  OUT_DATA <= FIFO_DATA;
               end else begin
                  OUT_DATA <= q1;
                  q1       <= FIFO_DATA;
               end
            end
            default: begin
            end
         endcase
      end
   end

`ifdef DRAIN_STATS_EN
   // Saturating delivery and stall counters
   always_ff @(posedge RCLK or negedge RST_n) begin
      if (!RST_n) begin
         WORD_CNT  <= '0;
         STALL_CNT <= '0;
      end else begin
         if (pop_c && (WORD_CNT != 32'hFFFF_FFFF)) begin
            WORD_CNT <= WORD_CNT + 32'd1;
         end
         if (OUT_VALID && !OUT_READY && (STALL_CNT != 32'hFFFF_FFFF)) begin
            STALL_CNT <= STALL_CNT + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_async_fifo_drain.sv
// Directed bench for async_fifo_drain: vector table of drain scenarios plus reset, push/pop and glitch sequences.
module tb_async_fifo_drain;

   logic       RCLK = 1'b0;
   logic       RST_n;
   logic       FIFO_EMPTY;
   logic [7:0] FIFO_DATA;
   logic       R_EN;
   logic       OUT_VALID;
   logic       OUT_READY;
   logic [7:0] OUT_DATA;
`ifdef DRAIN_STATS_EN
   logic [31:0] WORD_CNT;
   logic [31:0] STALL_CNT;
`endif

   always #5 RCLK = ~RCLK;

   async_fifo_drain #(
      .P_DATA_WIDTH (8),
      .SYNC_STAGES  (2),
      .RD_PULSE_W   (1)
   ) dut (
      .RCLK       (RCLK),
      .RST_n      (RST_n),
      .FIFO_EMPTY (FIFO_EMPTY),
      .FIFO_DATA  (FIFO_DATA),
      .R_EN       (R_EN),
      .OUT_VALID  (OUT_VALID),
      .OUT_READY  (OUT_READY),
`ifdef DRAIN_STATS_EN
      .WORD_CNT   (WORD_CNT),
      .STALL_CNT  (STALL_CNT),
`endif
      .OUT_DATA   (OUT_DATA)
   );

   typedef struct {
      int         n_words;
      logic [7:0] base;
      int         low_cycles;
      int         run_cycles;
      int         exp_low_pulses;
      int         exp_valid_cycles;
   } vec_t;

   vec_t       vecs[5];
   logic [7:0] fifo_q[$];
   logic [7:0] got[$];
   int         rises[$];
   int         cyc, ren_cycles, valid_cycles, first_valid, stall_model;
   logic       ren_prev, glitch;
   int         tests = 0;
   int         fails = 0;

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic refresh();
      FIFO_EMPTY = (fifo_q.size() == 0) || glitch;
      FIFO_DATA  = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
   endtask

   task automatic clear_obs();
      got.delete();
      rises.delete();
      cyc          = 0;
      ren_cycles   = 0;
      valid_cycles = 0;
      first_valid  = -1;
      stall_model  = 0;
      ren_prev     = 1'b0;
   endtask

   // One clock: record what the coming edge does, then update the FIFO model after it
   task automatic cycle();
      logic pop_now;
      if (OUT_VALID && OUT_READY) got.push_back(OUT_DATA);
      if (OUT_VALID && !OUT_READY) stall_model++;
      pop_now = R_EN;
      @(negedge RCLK);
      if (pop_now && fifo_q.size() != 0) void'(fifo_q.pop_front());
      refresh();
      cyc++;
      if (R_EN) ren_cycles++;
      if (R_EN && !ren_prev) rises.push_back(cyc);
      ren_prev = R_EN;
      if (OUT_VALID) begin
         valid_cycles++;
         if (first_valid < 0) first_valid = cyc;
      end
   endtask

   task automatic do_reset();
      RST_n     = 1'b0;
      OUT_READY = 1'b0;
      glitch    = 1'b0;
      fifo_q.delete();
      refresh();
      repeat (2) @(negedge RCLK);
      RST_n = 1'b1;
      clear_obs();
   endtask

   task automatic wait_rises(input string name, input int n);
      for (int k = 0; k < 60 && rises.size() < n; k++) cycle();
      check(name, (rises.size() >= n) ? 1 : 0, 1);
   endtask

   initial begin
      RST_n     = 1'b0;
      OUT_READY = 1'b0;
      glitch    = 1'b0;
      refresh();

      vecs[0] = '{1,  8'hA5, 0,  20, 0, 1};
      vecs[1] = '{10, 8'h00, 0,  70, 0, 10};
      vecs[2] = '{4,  8'h10, 40, 40, 2, -1};
      vecs[3] = '{2,  8'hF0, 40, 20, 2, -1};
      vecs[4] = '{3,  8'h7E, 6,  40, 1, -1};

      for (int v = 0; v < 5; v++) begin
         int hold_bad, order_bad, space_bad;
         do_reset();
         check($sformatf("v%0d_rst_ren", v), int'(R_EN), 0);
         check($sformatf("v%0d_rst_valid", v), int'(OUT_VALID), 0);
         check($sformatf("v%0d_rst_data", v), int'(OUT_DATA), 0);
         for (int i = 0; i < vecs[v].n_words; i++) fifo_q.push_back(vecs[v].base + 8'(i));
         refresh();
         hold_bad = 0;
         OUT_READY = (vecs[v].low_cycles == 0);
         for (int c = 0; c < vecs[v].low_cycles; c++) begin
            cycle();
            if (OUT_VALID && (OUT_DATA !== vecs[v].base)) hold_bad++;
         end
         if (vecs[v].low_cycles > 0) begin
            check($sformatf("v%0d_low_pulses", v), rises.size(), vecs[v].exp_low_pulses);
            check($sformatf("v%0d_hold_data", v), hold_bad, 0);
         end
         OUT_READY = 1'b1;
         repeat (vecs[v].run_cycles) cycle();

         check($sformatf("v%0d_delivered", v), got.size(), vecs[v].n_words);
         order_bad = 0;
         for (int i = 0; i < got.size() && i < vecs[v].n_words; i++)
            if (got[i] !== vecs[v].base + 8'(i)) order_bad++;
         check($sformatf("v%0d_order", v), order_bad, 0);
         check($sformatf("v%0d_pulses", v), rises.size(), vecs[v].n_words);
         check($sformatf("v%0d_ren_cycles", v), ren_cycles, vecs[v].n_words);
         check($sformatf("v%0d_first_rise", v), (rises.size() != 0) ? rises[0] : -1, 3);
         check($sformatf("v%0d_first_valid", v), first_valid, 4);
         if (vecs[v].exp_valid_cycles >= 0)
            check($sformatf("v%0d_valid_cycles", v), valid_cycles, vecs[v].exp_valid_cycles);
         if (vecs[v].low_cycles == 0) begin
            space_bad = 0;
            for (int k = 1; k < rises.size(); k++)
               if (rises[k] - rises[k-1] != 5) space_bad++;
            check($sformatf("v%0d_spacing", v), space_bad, 0);
         end
         check($sformatf("v%0d_idle_ren", v), int'(R_EN), 0);
         check($sformatf("v%0d_idle_valid", v), int'(OUT_VALID), 0);
`ifdef DRAIN_STATS_EN
         check($sformatf("v%0d_word_cnt", v), int'(WORD_CNT), vecs[v].n_words);
         check($sformatf("v%0d_stall_cnt", v), int'(STALL_CNT), stall_model);
`endif
      end

      // Push and pop on the same edge with one word already queued
      do_reset();
      fifo_q = '{8'hC1, 8'hC2, 8'hC3};
      refresh();
      wait_rises("pp_wait", 2);
      OUT_READY = 1'b1;
      cycle();
      check("pp_valid", int'(OUT_VALID), 1);
      check("pp_head", int'(OUT_DATA), 'hC2);
      repeat (30) cycle();
      check("pp_count", got.size(), 3);
      if (got.size() == 3) begin
         check("pp_w0", int'(got[0]), 'hC1);
         check("pp_w1", int'(got[1]), 'hC2);
         check("pp_w2", int'(got[2]), 'hC3);
      end

      // Reset while a read is in flight and a word is queued
      do_reset();
      fifo_q = '{8'hD1, 8'hD2, 8'hD3};
      refresh();
      wait_rises("rst_wait", 2);
      check("rst_pre_ren", int'(R_EN), 1);
      RST_n = 1'b0;
      #1;
      check("rst_async_ren", int'(R_EN), 0);
      check("rst_async_valid", int'(OUT_VALID), 0);
      check("rst_async_data", int'(OUT_DATA), 0);
      fifo_q.delete();
      refresh();
      repeat (2) @(negedge RCLK);
      RST_n = 1'b1;
      clear_obs();
      OUT_READY = 1'b1;
      repeat (20) cycle();
      check("rst_no_reads", rises.size(), 0);
      check("rst_no_words", got.size(), 0);

      // EMPTY glitching high during the pulse does not disturb the read
      do_reset();
      fifo_q = '{8'h3C};
      refresh();
      OUT_READY = 1'b1;
      wait_rises("gl_wait", 1);
      glitch = 1'b1;
      refresh();
      cycle();
      glitch = 1'b0;
      refresh();
      repeat (15) cycle();
      check("gl_ren_cycles", ren_cycles, 1);
      check("gl_count", got.size(), 1);
      if (got.size() == 1) check("gl_word", int'(got[0]), 'h3C);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, %0d tests run", tests);
      $fatal(1);
   end

endmodule
